// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- MIPS single-cycle datapath register file
//
// 2**addrWidth registers, each dataCount bits wide. Register 0 is hardwired to
// zero. Two combinational read ports feed the ALU / ALUSrc mux. One
// synchronous write port is driven by the RegDst mux (address) and the
// MemtoReg mux (data). The debug port always shows the stored value; it is
// never forwarded.
//
// Parameters
//   dataCount : data width of every register and data port
//   addrWidth : register address width (register count = 2**addrWidth)
//   bypass    : 1 = a write in progress is forwarded to a matching read port
//               in the same cycle; 0 = reads return the stored value only
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; clears every register
//   regWrite   in   write enable from the control unit
//   writeReg   in   destination register address
//   writeData  in   write-back data
//   readReg1   in   rs address
//   readReg2   in   rt address
//   readData1  out  contents of readReg1 (optionally forwarded)
//   readData2  out  contents of readReg2 (optionally forwarded)
//   dbgAddr    in   inspection address
//   dbgData    out  stored contents of dbgAddr
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int dataCount = 32,
  parameter int addrWidth = 5,
  parameter int bypass    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 regWrite,
  input  logic [addrWidth-1:0] writeReg,
  input  logic [dataCount-1:0] writeData,
  input  logic [addrWidth-1:0] readReg1,
  input  logic [addrWidth-1:0] readReg2,
  output logic [dataCount-1:0] readData1,
  output logic [dataCount-1:0] readData2,
  input  logic [addrWidth-1:0] dbgAddr,
  output logic [dataCount-1:0] dbgData
);

  localparam int NumRegs = 1 << addrWidth;

  logic [dataCount-1:0] regs_q [NumRegs];
  logic [dataCount-1:0] regs_d [NumRegs];

  // A write lands only for a non-zero destination; $zero silently drops it.
  logic wr_en;
  assign wr_en = regWrite && (writeReg != '0);

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[writeReg] = writeData;
    end
  end

  // ---- register array: async clear, single write port -----------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ---- combinational read ports ----------------------------------------------
  // The forward condition already excludes address 0 via wr_en, so $zero is
  // never overridden by a write aimed at it.
  logic fwd1, fwd2;
  generate
    if (bypass != 0) begin : g_bypass
      assign fwd1 = wr_en && (writeReg == readReg1);
      assign fwd2 = wr_en && (writeReg == readReg2);
    end else begin : g_no_bypass
      assign fwd1 = 1'b0;
      assign fwd2 = 1'b0;
    end
  endgenerate

  always_comb begin
    readData1 = '0;
    if (rst_n && (readReg1 != '0)) begin
      readData1 = fwd1 ? writeData : regs_q[readReg1];
    end
  end

  always_comb begin
    readData2 = '0;
    if (rst_n && (readReg2 != '0)) begin
      readData2 = fwd2 ? writeData : regs_q[readReg2];
    end
  end

  // Debug port shows the stored value only.
  always_comb begin
    dbgData = '0;
    if (rst_n && (dbgAddr != '0)) begin
      dbgData = regs_q[dbgAddr];
    end
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Register file for the MIPS single-cycle datapath.
- Sits directly downstream of the RegDst mux (which drives writeReg) and the MemtoReg mux (which drives writeData).
- Its read outputs feed the ALU and the ALUSrc mux.
- Provides two combinational read ports, one synchronous write port, a hardwired $zero, an optional write-through bypass, and a debug read port.

Parameters:
dataCount, 32, data width of every register and data port (same meaning as the datapath mux parameter)
addrWidth, 5, register address width; register count is 2**addrWidth
bypass, 1, 1 = same-cycle write-through forwarding onto read ports; 0 = reads return stored value only

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
regWrite  input  1  write enable from the control unit
writeReg  input  addrWidth  destination register address, from the RegDst mux
writeData  input  dataCount  write-back data, from the MemtoReg mux
readReg1  input  addrWidth  rs address
readReg2  input  addrWidth  rt address
readData1  output  dataCount  contents of readReg1
readData2  output  dataCount  contents of readReg2
dbgAddr  input  addrWidth  debug/testbench inspection address
dbgData  output  dataCount  contents of dbgAddr (never bypassed)

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset:
  - rst_n low clears all 2**addrWidth registers to 0 immediately, with no clock required.
  - While rst_n is low, readData1, readData2 and dbgData are 0, and writes are suppressed.
- Write:
  - On a rising clk edge with rst_n high and regWrite=1, regs[writeReg] <= writeData.
  - Write latency is 1 edge; the stored value is visible on dbgData after that edge.
- $zero:
  - Register 0 is never written; writes to address 0 are silently dropped.
  - Reads of address 0 always return 0 on all ports, with or without bypass.
- Read:
  - Purely combinational, zero latency.
  - readDataN = regs[readRegN], subject to the bypass rule below.
- Bypass (bypass=1):
  - Condition: regWrite=1 and writeReg==readRegN and writeReg!=0 and rst_n high.
  - When the condition holds, readDataN = writeData in the same cycle, before the edge.
  - Each read port evaluates the condition independently; both ports may forward simultaneously.
- Bypass (bypass=0): reads return the pre-edge stored value; the new value is visible after the edge.
- Simultaneous events:
  - A read and a write to the same address in one cycle follow the bypass rule.
  - Reset asserted at a clock edge wins, so no write occurs.
  - Reset deasserted coincident with an edge: a write on that edge is not required to land. The bench does not depend on it; the first valid write is on the next edge.
- No other state: no X propagation from uninitialised registers, since reset defines all of them.
- Widths:
  - Addresses are used unsigned.
  - No truncation or extension: writeData is stored exactly dataCount bits wide.

Test Plan:
1. Reset: hold rst_n=0 with regWrite=1, writeReg=3, writeData=32'hDEAD_BEEF, and clk toggling -> readData1 (readReg1=3)=0 and dbgData (dbgAddr=3)=0 throughout; after release with regWrite=0, still 0.
2. Basic write/read: write 32'h0000_1234 to reg 8, then 32'hFFFF_0001 to reg 9 -> next cycle, readReg1=8 and readReg2=9 give 32'h0000_1234 and 32'hFFFF_0001.
3. $zero: regWrite=1, writeReg=0, writeData=32'h5555_5555, readReg1=0 -> readData1=0 before and after the edge; dbgData at address 0 is 0.
4. Bypass: reg 10 holds 7; regWrite=1, writeReg=10, writeData=99, readReg1=readReg2=10 -> both outputs are 99 before the edge with bypass=1. With bypass=0 they are 7 before the edge, 99 after, and dbgData reads 7 then 99 in both builds.
5. Mid-operation reset: load regs 1..31 with their index, pulse rst_n low between edges -> all read ports immediately return 0 for every address.
6. Write disable: regWrite=0, writeReg=5, writeData=123 across 3 edges -> reg 5 keeps its previous value of 0.
